shift_ring_counter: RTL and testbench
=====================================

# shift_ring_counter

A parametrised ring/Johnson shift counter producing one-hot or thermometer-coded sequencing strobes for the ACA control datapath. It generalises the fixed 4-bit ring counter with:
- configurable width and seed
- runtime ring/Johnson mode
- shift direction
- count enable and parallel load
- a wrap pulse and an illegal-state flag
- optional self-correction from illegal states

## Interface
Parameters:
- WIDTH, default 4: counter width in bits. Must be ≥ 2.
- INIT, default {{(WIDTH-1){1'b0}},1'b1}: reset value and ring-mode seed. Must be one-hot.

Ports:
- clk  input  1  rising-edge clock; single clock domain.
- rst  input  1  asynchronous, active-low reset.
- en  input  1  shift enable.
- mode  input  1  0 = ring, 1 = Johnson (twisted ring).
- dir  input  1  0 = shift toward LSB (q[i] <= q[i+1]); 1 = shift toward MSB (q[i] <= q[i-1]).
- load  input  1  synchronous parallel load.
- load_val  input  WIDTH  value loaded when load = 1.
- q  output  WIDTH  counter state (registered).
- wrap  output  1  registered pulse; high in the cycle q returns to the seed through a shift.
- err  output  1  combinational; high while q is illegal for the current mode.

## Operation
- Reset (rst = 0, asynchronous): q = INIT, wrap = 0. err then follows q and mode combinationally.
- Priority per rising edge: load > en > hold.
- Load: q <= load_val, wrap <= 0. Any value is accepted, including illegal ones.
- Ring shift:
  - dir = 0: q <= {q[0], q[WIDTH-1:1]}
  - dir = 1: q <= {q[WIDTH-2:0], q[WIDTH-1]}
- Johnson shift:
  - dir = 0: q <= {~q[0], q[WIDTH-1:1]}
  - dir = 1: q <= {q[WIDTH-2:0], ~q[WIDTH-1]}
- Hold (en = 0, load = 0): q unchanged, wrap <= 0.
- Seed: INIT in ring mode; all zeros in Johnson mode.
- Period: WIDTH shifts in ring mode; 2·WIDTH shifts in Johnson mode, from any legal state.
- wrap <= 1 only when a shift (en = 1, load = 0) produces a next q equal to the current mode's seed; otherwise wrap <= 0.
- Legality:
  - Ring: q is legal iff popcount(q) == 1.
  - Johnson: q is legal iff at most one adjacent pair (q[i], q[i+1]), i = 0..WIDTH-2, differs. This gives exactly 2·WIDTH legal states.
  - err = !legal(q, mode). It responds to mode combinationally, with no register stage.
- Mode or dir change mid-sequence: takes effect on the next shift. No reseeding; the current q is shifted under the new rule.
- With the default INIT and mode = 1 out of reset, q = 0…01, which is a legal Johnson state. An INIT with its 1 in an interior bit sets err in Johnson mode.

## Timing
- Shift latency is one cycle: q updates on the rising edge where en = 1.
- wrap is high in the same cycle q shows the seed, and for exactly one cycle unless the following edge shifts back to the seed again (WIDTH = 2 only is not such a case; the seed recurs only once per period).
- err has zero latency from q and mode.
- A reset assertion between edges clears q and wrap immediately. Release is synchronous to the design's reset synchroniser, which lives outside this block.

## Configuration
- SHIFT_RING_SELF_CORRECT_EN defined:
  - On an enabled shift (en = 1, load = 0) while err = 1, q <= the current mode's seed instead of the shifted value.
  - wrap <= 1 on that correction.
  - load is never corrected.
- SHIFT_RING_SELF_CORRECT_EN undefined:
  - Illegal states shift normally and persist.
  - err stays high until a reset or a load restores a legal state.

## Test plan
All scenarios use WIDTH = 4 and INIT = 4'b0001.
- Ring, toward LSB: reset, then mode = 0, dir = 0, en = 1 -> q = 1000, 0100, 0010, 0001. wrap = 1 only with the fourth value; err = 0 throughout.
- Ring, toward MSB: reset, then dir = 1, en = 1 -> q = 0010, 0100, 1000, 0001. wrap pulses on 0001.
- Johnson: mode = 1, load 0000, then en = 1, dir = 0 -> q = 1000, 1100, 1110, 1111, 0111, 0011, 0001, 0000. wrap = 1 only on the eighth value; err = 0.
- Illegal state: mode = 0, load 0110 -> err = 1. On the next enabled shift:
  - without the macro, q = 0011 and err = 1;
  - with SHIFT_RING_SELF_CORRECT_EN, q = 0001, wrap = 1, err = 0.
- Priority and hold: load = 1, en = 1, load_val = 0100 -> q = 0100, wrap = 0. Then en = 0 for 3 cycles -> q holds 0100.
- Async reset mid-run: while shifting, at q = 0100, drive rst = 0 between edges -> q = 0001 and wrap = 0 before the next edge. Shifting resumes from 0001 after release.

Source files
------------

// File: rtl/shift_ring_counter.sv
// Parametrised ring/Johnson shift counter with registered wrap pulse and combinational illegal-state flag.
// Define SHIFT_RING_SELF_CORRECT_EN to replace an illegal state with the mode's seed on the next enabled shift.
module shift_ring_counter #(
    parameter int               WIDTH = 4,
    parameter logic [WIDTH-1:0] INIT  = {{(WIDTH-1){1'b0}}, 1'b1}
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             mode,
    input  logic             dir,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    output logic [WIDTH-1:0] q,
    output logic             wrap,
    output logic             err
);

    logic [WIDTH-1:0] seed;
    logic [WIDTH-1:0] shifted;
    logic [WIDTH-1:0] next_q;
    logic             next_wrap;
    logic             feed;
    int               ones;
    int               edges;

    // Johnson mode inverts the bit that wraps around the end of the register.
    always_comb begin
        seed = mode ? '0 : INIT;
        if (dir) begin
            feed    = q[WIDTH-1] ^ mode;
            shifted = {q[WIDTH-2:0], feed};
        end else begin
            feed    = q[0] ^ mode;
            shifted = {feed, q[WIDTH-1:1]};
        end
    end

    // Ring states are one-hot; Johnson states have at most one 0/1 boundary.
    always_comb begin
        ones  = 0;
        edges = 0;
        for (int i = 0; i < WIDTH; i++) begin
            if (q[i]) ones = ones + 1;
        end
        for (int i = 0; i < WIDTH - 1; i++) begin
            if (q[i] != q[i+1]) edges = edges + 1;
        end
        err = mode ? (edges > 1) : (ones != 1);
    end

    always_comb begin
        // NOTE: defaults first so every path assigns both signals and no latch is inferred.
        next_q    = q;
        next_wrap = 1'b0;
        if (load) begin
            next_q = load_val;
        end else if (en) begin
`ifdef SHIFT_RING_SELF_CORRECT_EN
            next_q = err ? seed : shifted;
`else
            next_q = shifted;
`endif
            next_wrap = (next_q == seed);
        end
    end

    // NOTE: non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            q    <= INIT;
            wrap <= 1'b0;
        end else begin
            q    <= next_q;
            wrap <= next_wrap;
        end
    end

endmodule

// File: tb/tb_shift_ring_counter.sv
// Self-checking bench for shift_ring_counter: directed sequences plus randomized stimulus against a behavioural model.
`timescale 1ns/1ps
module tb_shift_ring_counter;

    localparam int         W         = 4;
    localparam logic [3:0] SEED_RING = 4'b0001;
    localparam int         MASK      = (1 << W) - 1;

    logic         clk      = 1'b0;
    logic         rst      = 1'b0;
    logic         en       = 1'b0;
    logic         mode     = 1'b0;
    logic         dir      = 1'b0;
    logic         load     = 1'b0;
    logic [W-1:0] load_val = '0;
    logic [W-1:0] q;
    logic         wrap;
    logic         err;

    int checks   = 0;
    int errors   = 0;
    bit check_en = 1'b0;
    int m_q      = 1;
    bit m_wrap   = 1'b0;

    shift_ring_counter #(.WIDTH(W), .INIT(SEED_RING)) dut (
        .clk      (clk),
        .rst      (rst),
        .en       (en),
        .mode     (mode),
        .dir      (dir),
        .load     (load),
        .load_val (load_val),
        .q        (q),
        .wrap     (wrap),
        .err      (err)
    );

    initial forever #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks = checks + 1;
        if (act !== exp) begin
            errors = errors + 1;
            $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
        end
    endtask

    // Ring: a power of two. Johnson: a block of ones anchored at either end.
    function automatic bit legal(input int v, input bit md);
        int low;
        int high;
        if (!md) return (v != 0) && ((v & (v - 1)) == 0);
        for (int k = 0; k <= W; k++) begin
            low  = (1 << k) - 1;
            high = MASK & ~((1 << (W - k)) - 1);
            if (v == low || v == high) return 1'b1;
        end
        return 1'b0;
    endfunction

    function automatic int seed_of(input bit md);
        return md ? 0 : int'(SEED_RING);
    endfunction

    function automatic int shift_val(input int v, input bit md, input bit dr);
        int in_bit;
        if (!dr) begin
            in_bit = (v & 1) ^ int'(md);
            return (v >> 1) | (in_bit << (W - 1));
        end
        in_bit = ((v >> (W - 1)) & 1) ^ int'(md);
        return ((v << 1) & MASK) | in_bit;
    endfunction

    function automatic int model_next(input int v, input bit md, input bit dr,
                                      input bit ld, input int lv, input bit e);
        if (ld) return lv;
        if (!e) return v;
`ifdef SHIFT_RING_SELF_CORRECT_EN
        if (!legal(v, md)) return seed_of(md);
`endif
        return shift_val(v, md, dr);
    endfunction

    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            m_q    <= int'(SEED_RING);
            m_wrap <= 1'b0;
        end else begin
            m_q    <= model_next(m_q, mode, dir, load, int'(load_val), en);
            m_wrap <= !load && en &&
                      (model_next(m_q, mode, dir, load, int'(load_val), en) == seed_of(mode));
        end
    end

    always @(negedge clk) begin
        if (check_en) begin
            check("model_q", 32'(q), m_q);
            check("model_wrap", 32'(wrap), 32'(m_wrap));
            check("model_err", 32'(err), 32'(!legal(m_q, mode)));
        end
    end

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic pulse_reset();
        rst = 1'b0;
        tick();
        rst = 1'b1;
    endtask

    logic [3:0] ring_lsb [4] = '{4'b1000, 4'b0100, 4'b0010, 4'b0001};
    logic [3:0] ring_msb [4] = '{4'b0010, 4'b0100, 4'b1000, 4'b0001};
    logic [3:0] john     [8] = '{4'b1000, 4'b1100, 4'b1110, 4'b1111,
                                 4'b0111, 4'b0011, 4'b0001, 4'b0000};

    initial begin
        repeat (2) @(posedge clk);
        #2;
        check("reset_q", 32'(q), 32'h1);
        check("reset_wrap", 32'(wrap), 32'h0);
        check("reset_err", 32'(err), 32'h0);
        check_en = 1'b1;
        rst = 1'b1;
        tick();

        mode = 1'b0; dir = 1'b0; en = 1'b1;
        for (int i = 0; i < 4; i++) begin
            tick();
            check("ring_lsb_q", 32'(q), 32'(ring_lsb[i]));
            check("ring_lsb_wrap", 32'(wrap), 32'(i == 3));
            check("ring_lsb_err", 32'(err), 32'h0);
        end

        en = 1'b0;
        pulse_reset();
        dir = 1'b1; en = 1'b1;
        for (int i = 0; i < 4; i++) begin
            tick();
            check("ring_msb_q", 32'(q), 32'(ring_msb[i]));
            check("ring_msb_wrap", 32'(wrap), 32'(i == 3));
        end

        en = 1'b0; mode = 1'b1; load = 1'b1; load_val = 4'b0000;
        tick();
        check("john_load_q", 32'(q), 32'h0);
        check("john_load_wrap", 32'(wrap), 32'h0);
        load = 1'b0; en = 1'b1; dir = 1'b0;
        for (int i = 0; i < 8; i++) begin
            tick();
            check("john_q", 32'(q), 32'(john[i]));
            check("john_wrap", 32'(wrap), 32'(i == 7));
            check("john_err", 32'(err), 32'h0);
        end

        en = 1'b0; mode = 1'b0; load = 1'b1; load_val = 4'b0110;
        tick();
        load = 1'b0;
        check("illegal_err", 32'(err), 32'h1);
        en = 1'b1;
        tick();
        en = 1'b0;
`ifdef SHIFT_RING_SELF_CORRECT_EN
        check("correct_q", 32'(q), 32'h1);
        check("correct_wrap", 32'(wrap), 32'h1);
        check("correct_err", 32'(err), 32'h0);
`else
        check("persist_q", 32'(q), 32'h3);
        check("persist_wrap", 32'(wrap), 32'h0);
        check("persist_err", 32'(err), 32'h1);
`endif

        load = 1'b1; en = 1'b1; load_val = 4'b0100;
        tick();
        check("prio_q", 32'(q), 32'h4);
        check("prio_wrap", 32'(wrap), 32'h0);
        load = 1'b0; en = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            check("hold_q", 32'(q), 32'h4);
        end

        load = 1'b1; load_val = 4'b1000;
        tick();
        load = 1'b0; en = 1'b1; dir = 1'b0;
        tick();
        check("pre_reset_q", 32'(q), 32'h4);
        rst = 1'b0;
        #1;
        check("async_reset_q", 32'(q), 32'h1);
        check("async_reset_wrap", 32'(wrap), 32'h0);
        #1;
        rst = 1'b1;
        tick();
        check("resume_q", 32'(q), 32'h8);

        for (int n = 0; n < 3000; n++) begin
            load     = ($urandom_range(0, 9) == 0);
            load_val = 4'($urandom);
            en       = ($urandom_range(0, 3) != 0);
            if ($urandom_range(0, 19) == 0) mode = ~mode;
            if ($urandom_range(0, 9) == 0) dir = ~dir;
            if ($urandom_range(0, 99) == 0) rst = 1'b0;
            tick();
            rst = 1'b1;
        end

        check_en = 1'b0;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
